ring_monitor: RTL and testbench
===============================

# ring_monitor

Checker and encoder that sits directly downstream of the 8-bit ring counter and consumes its `counter` vector every clock. It confirms the vector is one-hot and advancing by exactly one position per step. It encodes the active bit to a binary position and counts full revolutions. It raises sticky error flags for corrupted, skipped or stalled patterns so the lab top can drive status LEDs and the bench can self-check.

## Interface
- `WIDTH`, 8, ring length in bits; 2..32.
- `PW`, $clog2(WIDTH), position width (derived, not overridden).
- `STALL_LIMIT`, 16, consecutive identical samples that constitute a stall; 1..255.
- `clk` input 1, rising-edge clock shared with the ring counter.
- `rst_n` input 1, asynchronous active-low reset.
- `counter` input WIDTH, ring counter output, same clock domain, sampled every rising edge.
- `clear` input 1, synchronous clear of statistics and sticky flags.
- `position` output PW, index of the set bit of the last valid sample.
- `pos_valid` output 1, high while `locked` and last sample was valid one-hot.
- `locked` output 1, FSM is in TRACK.
- `rev_count` output 16, completed revolutions; wraps at 16'hFFFF->0.
- `err_onehot` output 1, sticky: a sample had zero or more than one bit set.
- `err_skip` output 1, sticky: a step was not +1 mod WIDTH.
- `err_stall` output 1, sticky: pattern held STALL_LIMIT samples.
- `err_pulse` output 1, one-cycle pulse on any detected error.
- `err_count` output 8, detected errors; saturates at 255.

## Operation
- FSM states: IDLE (reset state, unlocked) and TRACK.
- Bit i of `counter` maps to position i. Legal step is from last_pos to (last_pos+1) mod WIDTH; LSB->MSB rotation, with MSB wrapping to bit 0.
- IDLE:
  - Valid one-hot sample -> TRACK; load last_pos and `position`; hold_cnt=0.
  - Invalid sample -> remain IDLE. No error is counted; `err_onehot` is set only in TRACK.
- TRACK, per sample, evaluated in priority order (only the first match fires):
  1. Not one-hot -> `err_onehot`, go to IDLE.
  2. Same index as last_pos -> hold_cnt+1. If hold_cnt+1 == STALL_LIMIT -> `err_stall`, go to IDLE.
  3. Index == last_pos+1 mod WIDTH -> advance, update `position`, hold_cnt=0. If last_pos == WIDTH-1 then `rev_count`+1.
  4. Any other index -> `err_skip`, go to IDLE. `position` is not updated.
- Every error event:
  - Sets its sticky flag.
  - Pulses `err_pulse` for one cycle.
  - Increments `err_count` (saturating).
  - Clears `locked` and `pos_valid` on the same edge.
- Leaving TRACK keeps `position` at its last value.
- Re-acquisition needs one valid sample in IDLE. A permanently held pattern therefore re-locks and re-faults every STALL_LIMIT+1 cycles.
- `clear`:
  - Zeroes `rev_count`, `err_count` and all sticky flags.
  - Does not change FSM state, `position` or hold_cnt.
  - If an error is detected in the same cycle as `clear`, the new error wins: its flag is set and `err_count` = 1.
  - If a revolution completes in the same cycle as `clear`, `rev_count` = 1.

## Timing
- All outputs are registered. An outcome for the sample taken at edge N is visible after edge N (1-cycle latency); decode and compare are combinational on `counter`.
- Reset (async assert, release synchronized by the bench timing only): state IDLE; all outputs 0; last_pos=0, hold_cnt=0.
- Reset asserted mid-operation aborts immediately. All outputs read 0 while `rst_n`=0.
- The first edge after release with a valid `counter` gives `locked`=1 and `pos_valid`=1.
- `err_pulse` is high exactly one cycle per error event. Back-to-back errors cannot occur, because each error forces IDLE and the next error requires TRACK.

## Test plan
- Reset/lock:
  - Stimulus: `rst_n`=0 for 13 ns with `counter`=8'h01, then release.
  - Required: all outputs 0 during reset; after the first edge, `locked`=1, `pos_valid`=1, `position`=0.
- Normal rotation:
  - Stimulus: 24 single steps starting from 8'h01 (01,02,...,80,01,...).
  - Required: `position` follows 0..7 cyclically; `rev_count` increments on each 80->01 step, reaching 3; all error flags and `err_count` stay 0.
- Invalid pattern:
  - Stimulus: 8'h02 then 8'h03, then 8'h04.
  - Required on the 8'h03 sample: `err_onehot`=1, `err_pulse`=1 for one cycle, `err_count`=1, `locked`=0, `position` stays 1.
  - Required on the 8'h04 sample: re-lock with `position`=2, `err_onehot` stays 1.
- Skip:
  - Stimulus: 8'h02 then 8'h08.
  - Required: `err_skip`=1, `err_count`+1, `locked`=0.
  - Stimulus: then 8'h10. Required: re-lock at `position`=4.
- Stall:
  - Stimulus: lock on 8'h10, then hold it, with STALL_LIMIT=16.
  - Required: `err_stall` and `err_pulse` on the 16th identical sample after the lock sample; re-lock on the next edge; second stall error 17 edges later.
- Clear collisions and reset mid-run:
  - Stimulus: assert `clear` in the same cycle as a skip.
  - Required: `err_skip`=1, `err_count`=1, `rev_count`=0.
  - Stimulus: pulse `rst_n` low mid-rotation.
  - Required: outputs drop to 0 asynchronously, then re-lock on the first valid sample.

Source files
------------

// File: rtl/ring_monitor.sv
// One-hot ring counter checker: encodes the active bit, counts revolutions,
// and raises sticky flags for corrupted, skipped or stalled patterns.
module ring_monitor #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned PW          = $clog2(WIDTH),
    parameter int unsigned STALL_LIMIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] counter,
    input  logic             clear,
    output logic [PW-1:0]    position,
    output logic             pos_valid,
    output logic             locked,
    output logic [15:0]      rev_count,
    output logic             err_onehot,
    output logic             err_skip,
    output logic             err_stall,
    output logic             err_pulse,
    output logic [7:0]       err_count
);

    typedef enum logic {IDLE, TRACK} state_t;

    state_t        state;
    logic [PW-1:0] last_pos;
    logic [7:0]    hold_cnt;

    logic          onehot;
    logic [PW-1:0] idx;
    logic [PW-1:0] succ;
    logic          e_onehot;
    logic          e_skip;
    logic          e_stall;
    logic          any_err;
    logic          hold;
    logic          adv;
    logic          rev_done;

    // Decode the sample and find the legal successor of the last position
    always_comb begin
        onehot = (counter != '0) && ((counter & (counter - WIDTH'(1))) == '0);
        idx    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (counter[i]) idx = PW'(i);
        end
        succ = (last_pos == PW'(WIDTH - 1)) ? '0 : last_pos + PW'(1);
    end

    // Classify the sample in priority order while tracking
    always_comb begin
        e_onehot = 1'b0;
        e_skip   = 1'b0;
        e_stall  = 1'b0;
        hold     = 1'b0;
        adv      = 1'b0;
        if (state == TRACK) begin
            if (!onehot) begin
                e_onehot = 1'b1;
            end else if (idx == last_pos) begin
                hold    = 1'b1;
                e_stall = ((hold_cnt + 8'd1) == 8'(STALL_LIMIT));
            end else if (idx == succ) begin
                adv = 1'b1;
            end else begin
                e_skip = 1'b1;
            end
        end
        any_err  = e_onehot | e_skip | e_stall;
        rev_done = adv && (last_pos == PW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_pos   <= '0;
            hold_cnt   <= '0;
            position   <= '0;
            pos_valid  <= 1'b0;
            locked     <= 1'b0;
            rev_count  <= '0;
            err_onehot <= 1'b0;
            err_skip   <= 1'b0;
            err_stall  <= 1'b0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
        end else begin
            err_pulse <= any_err;

            case (state)
                IDLE: begin
                    if (onehot) begin
                        state     <= TRACK;
                        last_pos  <= idx;
                        position  <= idx;
                        hold_cnt  <= '0;
                        locked    <= 1'b1;
                        pos_valid <= 1'b1;
                    end
                end
                TRACK: begin
                    if (any_err) begin
                        state     <= IDLE;
                        locked    <= 1'b0;
                        pos_valid <= 1'b0;
                    end else if (hold) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end else if (adv) begin
                        last_pos <= idx;
                        position <= idx;
                        hold_cnt <= '0;
                    end
                end
            endcase

            // A new event in the clear cycle survives the clear
            err_onehot <= (err_onehot & ~clear) | e_onehot;
            err_skip   <= (err_skip   & ~clear) | e_skip;
            err_stall  <= (err_stall  & ~clear) | e_stall;

            if (clear) begin
                err_count <= {7'd0, any_err};
            end else if (any_err && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end

            if (clear) begin
                rev_count <= {15'd0, rev_done};
            end else if (rev_done) begin
                rev_count <= rev_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ring_monitor.sv
// Directed bench for ring_monitor: a sample-level reference model checked every
// cycle, plus hand-computed expectations at the key points.
module tb_ring_monitor;

    localparam int unsigned W     = 8;
    localparam int unsigned STALL = 16;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] counter;
    logic         clear;
    logic [2:0]   position;
    logic         pos_valid;
    logic         locked;
    logic [15:0]  rev_count;
    logic         err_onehot;
    logic         err_skip;
    logic         err_stall;
    logic         err_pulse;
    logic [7:0]   err_count;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_pos, m_last, m_hold, m_rev, m_errcnt;
    bit m_locked, m_eo, m_es, m_est, m_pulse;

    ring_monitor #(.WIDTH(W), .STALL_LIMIT(STALL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .counter    (counter),
        .clear      (clear),
        .position   (position),
        .pos_valid  (pos_valid),
        .locked     (locked),
        .rev_count  (rev_count),
        .err_onehot (err_onehot),
        .err_skip   (err_skip),
        .err_stall  (err_stall),
        .err_pulse  (err_pulse),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pos = 0; m_last = 0; m_hold = 0; m_rev = 0; m_errcnt = 0;
        m_locked = 0; m_eo = 0; m_es = 0; m_est = 0; m_pulse = 0;
    endfunction

    // One sample as the rules describe it, using plain integer arithmetic
    function automatic void model_step(input logic [W-1:0] v, input bit clr);
        int ones;
        int pos;
        bit e1, e2, e3, rev;
        ones = $countones(v);
        pos  = -1;
        e1 = 0; e2 = 0; e3 = 0; rev = 0;
        for (int i = 0; i < W; i++) begin
            if (v[i] && ones == 1) pos = i;
        end
        if (!m_locked) begin
            if (ones == 1) begin
                m_locked = 1; m_last = pos; m_pos = pos; m_hold = 0;
            end
        end else if (ones != 1) begin
            e1 = 1; m_locked = 0;
        end else if (pos == m_last) begin
            m_hold++;
            if (m_hold == STALL) begin
                e3 = 1; m_locked = 0;
            end
        end else if (pos == (m_last + 1) % W) begin
            rev = (m_last == W - 1);
            m_last = pos; m_pos = pos; m_hold = 0;
        end else begin
            e2 = 1; m_locked = 0;
        end
        if (clr) begin
            m_eo = 0; m_es = 0; m_est = 0; m_errcnt = 0; m_rev = 0;
        end
        m_eo  = m_eo  | e1;
        m_es  = m_es  | e2;
        m_est = m_est | e3;
        m_pulse = e1 | e2 | e3;
        if (m_pulse && m_errcnt < 255) m_errcnt++;
        if (rev) m_rev = (m_rev + 1) % 65536;
    endfunction

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("position",   int'(position),   m_pos);
        chk("pos_valid",  int'(pos_valid),  int'(m_locked));
        chk("locked",     int'(locked),     int'(m_locked));
        chk("rev_count",  int'(rev_count),  m_rev);
        chk("err_onehot", int'(err_onehot), int'(m_eo));
        chk("err_skip",   int'(err_skip),   int'(m_es));
        chk("err_stall",  int'(err_stall),  int'(m_est));
        chk("err_pulse",  int'(err_pulse),  int'(m_pulse));
        chk("err_count",  int'(err_count),  m_errcnt);
    end

    task automatic step(input logic [W-1:0] v, input bit clr);
        counter = v;
        clear   = clr;
        @(posedge clk);
        model_step(v, clr);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rst_n   = 1'b0;
        counter = 8'h01;
        clear   = 1'b0;
        #3;
        chk("rst_locked", int'(locked), 0);
        chk("rst_position", int'(position), 0);
        chk("rst_err_count", int'(err_count), 0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        model_step(8'h01, 1'b0);
        @(negedge clk);
        #1;
        chk("lock_locked", int'(locked), 1);
        chk("lock_pos_valid", int'(pos_valid), 1);
        chk("lock_position", int'(position), 0);

        // Normal rotation: three full revolutions
        for (int i = 1; i <= 24; i++) step(8'(1 << (i % 8)), 1'b0);
        chk("rot_rev_count", int'(rev_count), 3);
        chk("rot_position", int'(position), 0);
        chk("rot_err_count", int'(err_count), 0);

        // Invalid pattern
        step(8'h02, 1'b0);
        step(8'h03, 1'b0);
        chk("inv_err_onehot", int'(err_onehot), 1);
        chk("inv_err_pulse", int'(err_pulse), 1);
        chk("inv_err_count", int'(err_count), 1);
        chk("inv_locked", int'(locked), 0);
        chk("inv_position", int'(position), 1);
        step(8'h04, 1'b0);
        chk("inv_relock", int'(locked), 1);
        chk("inv_relock_pos", int'(position), 2);
        chk("inv_sticky", int'(err_onehot), 1);
        chk("inv_pulse_low", int'(err_pulse), 0);

        // Skip from position 1 to 3
        step(8'h08, 1'b0); step(8'h10, 1'b0); step(8'h20, 1'b0);
        step(8'h40, 1'b0); step(8'h80, 1'b0); step(8'h01, 1'b0);
        chk("rev_after_inv", int'(rev_count), 4);
        step(8'h02, 1'b0);
        step(8'h08, 1'b0);
        chk("skip_err_skip", int'(err_skip), 1);
        chk("skip_err_count", int'(err_count), 2);
        chk("skip_locked", int'(locked), 0);
        chk("skip_position", int'(position), 1);
        step(8'h10, 1'b0);
        chk("skip_relock_pos", int'(position), 4);
        chk("skip_relock", int'(locked), 1);

        // Stall: locked on 8'h10, hold it
        for (int i = 0; i < 15; i++) step(8'h10, 1'b0);
        chk("stall_not_yet", int'(err_stall), 0);
        step(8'h10, 1'b0);
        chk("stall_flag", int'(err_stall), 1);
        chk("stall_pulse", int'(err_pulse), 1);
        chk("stall_count", int'(err_count), 3);
        chk("stall_locked", int'(locked), 0);
        step(8'h10, 1'b0);
        chk("stall_relock", int'(locked), 1);
        for (int i = 0; i < 15; i++) step(8'h10, 1'b0);
        chk("stall2_not_yet", int'(err_count), 3);
        step(8'h10, 1'b0);
        chk("stall2_pulse", int'(err_pulse), 1);
        chk("stall2_count", int'(err_count), 4);

        // Clear colliding with a skip
        step(8'h20, 1'b0);
        step(8'h40, 1'b0);
        step(8'h01, 1'b1);
        chk("clr_err_skip", int'(err_skip), 1);
        chk("clr_err_count", int'(err_count), 1);
        chk("clr_rev_count", int'(rev_count), 0);
        chk("clr_err_stall", int'(err_stall), 0);
        chk("clr_err_onehot", int'(err_onehot), 0);

        // Clear colliding with a revolution
        step(8'h80, 1'b0);
        step(8'h01, 1'b1);
        chk("clr_rev_one", int'(rev_count), 1);
        chk("clr_rev_errcnt", int'(err_count), 0);
        chk("clr_rev_skip", int'(err_skip), 0);

        // Reset mid-rotation
        step(8'h02, 1'b0);
        step(8'h04, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_locked", int'(locked), 0);
        chk("mid_rst_position", int'(position), 0);
        chk("mid_rst_rev", int'(rev_count), 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        step(8'h08, 1'b0);
        chk("mid_relock", int'(locked), 1);
        chk("mid_relock_pos", int'(position), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
